// File: rtl/vram_arbiter_if.sv
// ISA host and pixel-fetch signal bundle for vram_arbiter. The testbench or
// ISA glue connects through 'master'; the arbiter connects through 'slave'.
interface vram_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] isa_addr;
  logic [DATA_W-1:0] isa_din;
  logic [DATA_W-1:0] isa_dout;
  logic              isa_read;
  logic              isa_write;
  logic              isa_wfull;
  logic              wr_overflow;
  logic [ADDR_W-1:0] pixel_addr;
  logic              pixel_read;
  logic [DATA_W-1:0] pixel_data;

  modport master (
    output isa_addr, isa_din, isa_read, isa_write, pixel_addr, pixel_read,
    input  isa_dout, isa_wfull, wr_overflow, pixel_data
  );

  modport slave (
    input  isa_addr, isa_din, isa_read, isa_write, pixel_addr, pixel_read,
    output isa_dout, isa_wfull, wr_overflow, pixel_data
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-SRAM arbiter between ISA host (posted writes, forwarded reads) and pixel fetch.
// Define VRAM_SNOWFREE_EN to drain writes only in pixel-idle slots (no snow).
module vram_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 8,
  parameter int WFIFO_DEPTH  = 4,
  parameter int WRITE_SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_l,
  vram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] ram_a,
  inout  wire  [DATA_W-1:0] ram_d,
  output logic              ram_ce_l,
  output logic              ram_oe_l,
  output logic              ram_we_l
);

  localparam int PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SET_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE
  } drain_state_e;

  drain_state_e      state_q, state_d;
  logic              isa_write_q;
  logic              cap_busy_q, cap_busy_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic              wr_overflow_q;
  logic [DATA_W-1:0] pixel_data_q, pixel_data_d;

  logic [ADDR_W-1:0] fifo_addr_q [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  logic write_edge, push, push_ok, pop, fifo_full, slot_ok, pixel_own, pixel_lost;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  fwd_idx;

  assign write_edge = bus.isa_write & ~isa_write_q;
  assign fifo_full  = (count_q == CNT_W'(WFIFO_DEPTH));
  assign push_ok    = push & ~fifo_full;
  assign pop        = (state_q == ST_STROBE);

  // Capture: latch the address on the strobe edge, sample data WRITE_SETTLE clocks later.
  always_comb begin
    cap_busy_d = cap_busy_q;
    settle_d   = settle_q;
    cap_addr_d = cap_addr_q;
    push       = 1'b0;
    if (write_edge) begin
      cap_busy_d = 1'b1;
      settle_d   = SET_W'(WRITE_SETTLE);
      cap_addr_d = bus.isa_addr;
    end else if (cap_busy_q) begin
      settle_d = settle_q - SET_W'(1);
      if (settle_q == SET_W'(1)) begin
        push       = 1'b1;
        cap_busy_d = 1'b0;
      end
    end
  end

  // NOTE: the entry storage has no reset; count_q alone says which slots are valid,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_addr_q[wr_ptr_q] <= cap_addr_q;
      fifo_data_q[wr_ptr_q] <= bus.isa_din;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to newest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < WFIFO_DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (fifo_addr_q[fwd_idx] == bus.isa_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_data_q[fwd_idx];
      end
    end
  end

`ifdef VRAM_SNOWFREE_EN
  assign slot_ok = ~bus.pixel_read;
`else
  assign slot_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if ((count_q != '0) && !bus.isa_read && slot_ok) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign pixel_own  = (state_q == ST_IDLE) && !bus.isa_read;
  assign pixel_lost = bus.pixel_read & ~pixel_own;

  always_comb begin
    pixel_data_d = pixel_data_q;
    if (pixel_own) begin
      pixel_data_d = ram_d;
    end else if (pixel_lost) begin
`ifdef VRAM_SNOWFREE_EN
      pixel_data_d = pixel_data_q;
`else
      pixel_data_d = '1;
`endif
    end
  end

  always_comb begin
    ram_a = bus.pixel_addr;
    if (state_q != ST_IDLE) ram_a = fifo_addr_q[rd_ptr_q];
    else if (bus.isa_read)  ram_a = bus.isa_addr;
  end

  // NOTE: write enable is decoded straight from the state register, so an
  // asynchronous reset mid-STROBE releases it without waiting for a clock.
  assign ram_we_l = (state_q != ST_STROBE);
  assign ram_ce_l = 1'b0;
  assign ram_oe_l = 1'b0;
  // Data is driven only in the low half of STROBE, giving address setup and data hold margin.
  assign ram_d    = ((state_q == ST_STROBE) && !clk) ? fifo_data_q[rd_ptr_q] : 'z;

  assign bus.isa_dout    = (bus.isa_read && fwd_hit) ? fwd_data : ram_d;
  assign bus.isa_wfull   = fifo_full;
  assign bus.wr_overflow = wr_overflow_q;
  assign bus.pixel_data  = pixel_data_q;

  // NOTE: every register below uses non-blocking assignment so all state updates
  // see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q       <= ST_IDLE;
      isa_write_q   <= 1'b1;
      cap_busy_q    <= 1'b0;
      settle_q      <= '0;
      cap_addr_q    <= '0;
      wr_overflow_q <= 1'b0;
      pixel_data_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      isa_write_q   <= bus.isa_write;
      cap_busy_q    <= cap_busy_d;
      settle_q      <= settle_d;
      cap_addr_q    <= cap_addr_d;
      wr_overflow_q <= push & fifo_full;
      pixel_data_q  <= pixel_data_d;
      count_q       <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

endmodule
